core_c1_exu_lsu_bus: RTL and testbench
======================================

# core_c1_exu_lsu_bus

Multi-cycle load/store unit for the C1 execute stage. It replaces the combinational LSU path with a registered data-bus master that has a request/grant/response handshake, byte-lane alignment, misalignment detection, bus-error reporting and a parametrised response timeout. It sits between the EXU decode outputs and the SoC data bus, and stalls the pipeline through `lsu_busy` until each access completes.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum number of cycles spent in REQ+WAIT before the access aborts. A value of 0 disables the timeout.
- `CNT_W`, default 8: width of the timeout counter. It must satisfy `TIMEOUT < 2**CNT_W`.

Ports:
- `clk` in 1: core clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_type_bus` in 8: instruction class. Bit 1 = load, bit 2 = store.
- `cmd_op_memory` in 8: one-hot operation. Bits [7:3] = LB/LH/LW/LBU/LHU; bits [2:0] = SB/SH/SW.
- `exu_rs1_data`, `exu_rs2_data`, `exu_imm32` in 32 each: base, store data, offset.
- `lsu_start` in 1: one-cycle pulse that launches the decoded access.
- `lsu_busy` out 1: high while the FSM is not in IDLE.
- `lsu_done` out 1: one-cycle completion pulse.
- `lsu_rd_valid` out 1: qualifies `lsu_rd_data`. It is high only together with `lsu_done` for a successful load.
- `lsu_rd_data` out 32: extended load result.
- `lsu_exc_misalign` out 1: misaligned access. Valid with `lsu_done`.
- `lsu_exc_fault` out 1: bus error or timeout. Valid with `lsu_done`.
- `lsu_exc_addr` out 32: effective address of the faulting access.
- `bus_req` out 1, `bus_we` out 1, `bus_addr` out 32, `bus_wdata` out 32, `bus_wstrb` out 4: request channel.
- `bus_gnt` in 1: request accepted.
- `bus_rvalid` in 1, `bus_rdata` in 32, `bus_err` in 1: response channel. Stores also receive a `bus_rvalid`.

## Operation
- Effective address: EA = rs1 + imm32, modulo 2^32. It is captured together with the op, the size and rs2 when `lsu_start` is sampled in IDLE.
- `lsu_start` is ignored in these cases:
  - while busy;
  - when neither load nor store is set;
  - when no op bit is set.
- Misalignment rules:
  - H and HU accesses require EA[0]=0.
  - W accesses require EA[1:0]=0.
  - A misaligned access issues no bus request and goes to DONE with `lsu_exc_misalign`=1.
- States are IDLE, REQ, WAIT and DONE:
  - IDLE -> REQ on an accepted aligned start. IDLE -> DONE on a misaligned start.
  - REQ holds `bus_req`=1 with stable address, we, wdata and wstrb until `bus_gnt`=1, then goes to WAIT.
  - WAIT -> DONE on `bus_rvalid`. If `bus_err`=1 at that point, the access ends with a fault and the write to rd is suppressed.
  - REQ or WAIT -> DONE when the timeout counter reaches TIMEOUT. This sets `lsu_exc_fault`=1 and drops `bus_req`.
  - DONE -> IDLE unconditionally after one cycle.
- Bus request fields:
  - `bus_addr` = {EA[31:2], 2'b00}.
  - SB: wdata = rs2[7:0] replicated ×4; wstrb = 4'b0001 << EA[1:0].
  - SH: wdata = rs2[15:0] replicated ×2; wstrb = 4'b0011 << EA[1:0].
  - SW: wdata = rs2; wstrb = 4'hF.
  - Loads: wstrb = 0 and we = 0.
- Load extraction:
  - The byte is taken from `bus_rdata` >> (8·EA[1:0]); the halfword from `bus_rdata` >> (16·EA[1]).
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - The result is registered into `lsu_rd_data` in the WAIT -> DONE transition.
- The timeout counter clears on entering REQ. It increments every cycle in REQ and WAIT, and saturates.
- `bus_rvalid` or `bus_gnt` received in IDLE or DONE is ignored; a late response is not used.

## Timing
- Reset values:
  - `state` = IDLE.
  - All outputs = 0, including `lsu_rd_data`, `lsu_exc_addr`, `bus_addr`, `bus_wdata` and `bus_wstrb`.
- All outputs are registered except `lsu_busy`, which is decoded from the state.
- Cycle sequence, with start sampled at cycle T:
  - `bus_req` is high from T+1.
  - If `gnt` arrives at T+k (k≥1), the FSM enters WAIT at T+k+1.
  - If `rvalid` arrives at T+m (m≥k+1), `lsu_done` is high at T+m+1.
  - Minimum latency is 3 cycles, with gnt at T+1 and rvalid at T+2.
- `bus_rvalid` is only accepted in WAIT. A response in the same cycle as `gnt` is not supported.
- A misaligned access gives `lsu_done` at T+1 with no bus activity.
- Timeout: with a request never granted, `lsu_done` and `lsu_exc_fault` are high at T+TIMEOUT+1.
- `lsu_busy` is high from T+1 through the DONE cycle inclusive. A new start is accepted in the cycle after DONE.
- Asserting `rst_n` mid-access returns the FSM to IDLE and drops `bus_req` immediately, without waiting for a clock edge.

## Test plan
- Load LBU and LB: rs1=0x100, imm=3, rdata=0x80FF_0011, gnt at T+1, rvalid at T+2.
  - bus_addr=0x100; done at T+3.
  - LBU gives rd=0x0000_0080; LB gives rd=0xFFFF_FF80.
- SH: EA=0x202, rs2=0x1234_ABCD.
  - wstrb=4'b1100, wdata=0xABCD_ABCD, we=1.
  - After rvalid: done with rd_valid=0.
- LW at EA=0x101 → done at T+1 with misalign=1, exc_addr=0x101, and bus_req never asserted.
- gnt held low for 3 cycles: req and address stay stable throughout; then gnt is accepted and the response completes with the correct data.
- Timeout and error:
  - TIMEOUT=4 with gnt never asserted → fault at T+5.
  - rvalid with err=1 → fault=1 and rd_valid=0.
- Reset asserted during WAIT → outputs are 0 and the state is IDLE; a late rvalid after reset is ignored; a following start works.

Source files
------------

// File: rtl/core_c1_exu_lsu_bus.sv
// C1 execute-stage load/store unit: registered data-bus master with
// req/gnt/rvalid handshake, byte-lane alignment, misalignment detection,
// bus-error reporting and a saturating response timeout.
module core_c1_exu_lsu_bus #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  cmd_type_bus,
    input  logic [7:0]  cmd_op_memory,
    input  logic [31:0] exu_rs1_data,
    input  logic [31:0] exu_rs2_data,
    input  logic [31:0] exu_imm32,
    input  logic        lsu_start,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic        lsu_rd_valid,
    output logic [31:0] lsu_rd_data,
    output logic        lsu_exc_misalign,
    output logic        lsu_exc_fault,
    output logic [31:0] lsu_exc_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    // Counter value seen in the last permitted REQ/WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      ea_q, ea_d;
    logic [4:0]       ld_op_q, ld_op_d;   // LB, LH, LW, LBU, LHU
    logic             done_q, done_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             misalign_q, misalign_d;
    logic             fault_q, fault_d;
    logic [31:0]      exc_addr_q, exc_addr_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;

    logic [31:0]      ea_new;
    logic             start_ok;
    logic             new_load;
    logic             new_half;
    logic             new_word;
    logic             new_misalign;
    logic [31:0]      new_wdata;
    logic [3:0]       new_wstrb;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_inc;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;
    logic [31:0]      load_res;
    logic             unused_type_bits;

    assign unused_type_bits = ^{cmd_type_bus[7:3], cmd_type_bus[0]};

    // Decode of the incoming command: EA, size, misalignment and store lanes.
    always_comb begin
        ea_new       = exu_rs1_data + exu_imm32;
        start_ok     = lsu_start && (cmd_type_bus[1] || cmd_type_bus[2]) && (|cmd_op_memory);
        new_load     = |cmd_op_memory[7:3];
        new_half     = cmd_op_memory[6] | cmd_op_memory[3] | cmd_op_memory[1];
        new_word     = cmd_op_memory[5] | cmd_op_memory[0];
        new_misalign = (new_half && ea_new[0]) || (new_word && (ea_new[1:0] != 2'b00));
        new_wdata    = '0;
        new_wstrb    = '0;
        if (cmd_op_memory[2]) begin
            new_wdata = {4{exu_rs2_data[7:0]}};
            new_wstrb = 4'b0001 << ea_new[1:0];
        end else if (cmd_op_memory[1]) begin
            new_wdata = {2{exu_rs2_data[15:0]}};
            new_wstrb = 4'b0011 << ea_new[1:0];
        end else if (cmd_op_memory[0]) begin
            new_wdata = exu_rs2_data;
            new_wstrb = 4'hF;
        end
    end

    // Load lane extraction and sign/zero extension from the response word.
    always_comb begin
        byte_sel = 8'(bus_rdata >> {ea_q[1:0], 3'b000});
        half_sel = 16'(bus_rdata >> {ea_q[1], 4'b0000});
        load_res = '0;
        unique case (1'b1)
            ld_op_q[4]: load_res = {{24{byte_sel[7]}}, byte_sel};
            ld_op_q[3]: load_res = {{16{half_sel[15]}}, half_sel};
            ld_op_q[2]: load_res = bus_rdata;
            ld_op_q[1]: load_res = {24'h0, byte_sel};
            ld_op_q[0]: load_res = {16'h0, half_sel};
            default:    load_res = '0;
        endcase
    end

    // Next-state and registered-output computation for the access FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ea_d        = ea_q;
        ld_op_d     = ld_op_q;
        done_d      = 1'b0;
        rd_valid_d  = 1'b0;
        rd_data_d   = rd_data_q;
        misalign_d  = 1'b0;
        fault_d     = 1'b0;
        exc_addr_d  = exc_addr_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        timeout_hit = TO_EN && (cnt_q == CNT_LAST);

        unique case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    ea_d    = ea_new;
                    ld_op_d = cmd_op_memory[7:3];
                    if (new_misalign) begin
                        state_d    = S_DONE;
                        done_d     = 1'b1;
                        misalign_d = 1'b1;
                        exc_addr_d = ea_new;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = ~new_load;
                        addr_d  = {ea_new[31:2], 2'b00};
                        wdata_d = new_wdata;
                        wstrb_d = new_wstrb;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_inc;
                if (timeout_hit) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    fault_d    = 1'b1;
                    exc_addr_d = ea_q;
                    req_d      = 1'b0;
                end else if (bus_gnt) begin
                    state_d = S_WAIT;
                    req_d   = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A response arriving in the final permitted cycle still completes normally.
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (bus_err) begin
                        fault_d    = 1'b1;
                        exc_addr_d = ea_q;
                    end else if (|ld_op_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = load_res;
                    end
                end else if (timeout_hit) begin
                    state_d    = S_DONE;
                    done_d     = 1'b1;
                    fault_d    = 1'b1;
                    exc_addr_d = ea_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ea_q       <= '0;
            ld_op_q    <= '0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            exc_addr_q <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ea_q       <= ea_d;
            ld_op_q    <= ld_op_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            exc_addr_q <= exc_addr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
        end
    end

    assign lsu_busy         = (state_q != S_IDLE);
    assign lsu_done         = done_q;
    assign lsu_rd_valid     = rd_valid_q;
    assign lsu_rd_data      = rd_data_q;
    assign lsu_exc_misalign = misalign_q;
    assign lsu_exc_fault    = fault_q;
    assign lsu_exc_addr     = exc_addr_q;
    assign bus_req          = req_q;
    assign bus_we           = we_q;
    assign bus_addr         = addr_q;
    assign bus_wdata        = wdata_q;
    assign bus_wstrb        = wstrb_q;

endmodule

// File: tb/tb_core_c1_exu_lsu_bus.sv
// Directed bench for core_c1_exu_lsu_bus: loads, stores, misalignment,
// grant stall, timeout, bus error and mid-access reset.
module tb_core_c1_exu_lsu_bus;

    localparam logic [7:0] T_LOAD  = 8'h02;
    localparam logic [7:0] T_STORE = 8'h04;
    localparam logic [7:0] OP_LB   = 8'h80;
    localparam logic [7:0] OP_LW   = 8'h20;
    localparam logic [7:0] OP_LBU  = 8'h10;
    localparam logic [7:0] OP_LHU  = 8'h08;
    localparam logic [7:0] OP_SB   = 8'h04;
    localparam logic [7:0] OP_SH   = 8'h02;

    logic        clk;
    logic        rst_n;
    logic [7:0]  cmd_type_bus;
    logic [7:0]  cmd_op_memory;
    logic [31:0] rs1, rs2, imm;
    logic        lsu_start;
    logic        start_to;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        bus_err;

    logic        busy, done, rd_valid, misalign, fault;
    logic [31:0] rd_data, exc_addr;
    logic        req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;

    logic        t_busy, t_done, t_rd_valid, t_misalign, t_fault;
    logic [31:0] t_rd_data, t_exc_addr;
    logic        t_req, t_we;
    logic [31:0] t_addr, t_wdata;
    logic [3:0]  t_wstrb;

    int n_cmp;
    int n_bad;

    core_c1_exu_lsu_bus dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_type_bus(cmd_type_bus), .cmd_op_memory(cmd_op_memory),
        .exu_rs1_data(rs1), .exu_rs2_data(rs2), .exu_imm32(imm),
        .lsu_start(lsu_start), .lsu_busy(busy), .lsu_done(done),
        .lsu_rd_valid(rd_valid), .lsu_rd_data(rd_data),
        .lsu_exc_misalign(misalign), .lsu_exc_fault(fault), .lsu_exc_addr(exc_addr),
        .bus_req(req), .bus_we(we), .bus_addr(addr), .bus_wdata(wdata), .bus_wstrb(wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    // Second instance with a short timeout and a bus that never grants.
    core_c1_exu_lsu_bus #(.TIMEOUT(4), .CNT_W(8)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .cmd_type_bus(cmd_type_bus), .cmd_op_memory(cmd_op_memory),
        .exu_rs1_data(rs1), .exu_rs2_data(rs2), .exu_imm32(imm),
        .lsu_start(start_to), .lsu_busy(t_busy), .lsu_done(t_done),
        .lsu_rd_valid(t_rd_valid), .lsu_rd_data(t_rd_data),
        .lsu_exc_misalign(t_misalign), .lsu_exc_fault(t_fault), .lsu_exc_addr(t_exc_addr),
        .bus_req(t_req), .bus_we(t_we), .bus_addr(t_addr), .bus_wdata(t_wdata), .bus_wstrb(t_wstrb),
        .bus_gnt(1'b0), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command in the current cycle T; returns in cycle T+1.
    task automatic issue(input logic [7:0] ty, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] o);
        cmd_type_bus  = ty;
        cmd_op_memory = op;
        rs1           = a;
        rs2           = d;
        imm           = o;
        lsu_start     = 1'b1;
        tick();
        lsu_start     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        cmd_type_bus = '0; cmd_op_memory = '0;
        rs1 = '0; rs2 = '0; imm = '0;
        lsu_start = 1'b0; start_to = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", req, 0);
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wstrb", wstrb, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        tick();

        // Start with no instruction class set is ignored
        issue(8'h00, OP_LW, 32'h100, 0, 0);
        chk("nocls_busy", busy, 0);
        chk("nocls_req", req, 0);
        tick();

        // LBU at EA 0x103
        issue(T_LOAD, OP_LBU, 32'h100, 0, 3);
        chk("lbu_busy", busy, 1);
        chk("lbu_req", req, 1);
        chk("lbu_addr", addr, 32'h100);
        chk("lbu_we", we, 0);
        chk("lbu_wstrb", wstrb, 0);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("lbu_req_drop", req, 0);
        chk("lbu_done_early", done, 0);
        bus_rvalid = 1'b1; bus_rdata = 32'h80FF_0011;
        tick();
        bus_rvalid = 1'b0;
        chk("lbu_done", done, 1);
        chk("lbu_rd_valid", rd_valid, 1);
        chk("lbu_rd_data", rd_data, 32'h0000_0080);
        chk("lbu_fault", fault, 0);
        chk("lbu_busy_done", busy, 1);
        tick();
        chk("lbu_idle", busy, 0);
        chk("lbu_done_pulse", done, 0);

        // LB at EA 0x103, issued in the cycle right after DONE
        issue(T_LOAD, OP_LB, 32'h100, 0, 3);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h80FF_0011;
        tick();
        bus_rvalid = 1'b0;
        chk("lb_done", done, 1);
        chk("lb_rd_data", rd_data, 32'hFFFF_FF80);
        tick();

        // SH at EA 0x202
        issue(T_STORE, OP_SH, 32'h200, 32'h1234_ABCD, 2);
        chk("sh_req", req, 1);
        chk("sh_we", we, 1);
        chk("sh_addr", addr, 32'h200);
        chk("sh_wstrb", wstrb, 4'b1100);
        chk("sh_wdata", wdata, 32'hABCD_ABCD);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h0;
        tick();
        bus_rvalid = 1'b0;
        chk("sh_done", done, 1);
        chk("sh_rd_valid", rd_valid, 0);
        tick();

        // SB at EA 0x301
        issue(T_STORE, OP_SB, 32'h2FF, 32'h0000_105A, 2);
        chk("sb_addr", addr, 32'h300);
        chk("sb_wstrb", wstrb, 4'b0010);
        chk("sb_wdata", wdata, 32'h5A5A_5A5A);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        chk("sb_done", done, 1);
        tick();

        // Misaligned LW at EA 0x101
        issue(T_LOAD, OP_LW, 32'h100, 0, 1);
        chk("mis_done", done, 1);
        chk("mis_flag", misalign, 1);
        chk("mis_exc_addr", exc_addr, 32'h101);
        chk("mis_req", req, 0);
        chk("mis_busy", busy, 1);
        tick();
        chk("mis_req2", req, 0);
        chk("mis_idle", busy, 0);
        chk("mis_flag_clr", misalign, 0);

        // LHU at EA 0x402 with grant withheld for three cycles
        issue(T_LOAD, OP_LHU, 32'h400, 0, 2);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", req, 1);
            chk("stall_addr", addr, 32'h400);
            tick();
        end
        bus_gnt = 1'b1;
        chk("stall_req_last", req, 1);
        tick();
        bus_gnt = 1'b0;
        chk("stall_req_drop", req, 0);
        bus_rvalid = 1'b1; bus_rdata = 32'hBEEF_1234;
        tick();
        bus_rvalid = 1'b0;
        chk("stall_done", done, 1);
        chk("stall_rd_valid", rd_valid, 1);
        chk("stall_rd_data", rd_data, 32'h0000_BEEF);
        tick();

        // Timeout on the TIMEOUT=4 instance: never granted
        cmd_type_bus = T_LOAD; cmd_op_memory = OP_LW; rs1 = 32'h500; imm = 0;
        start_to = 1'b1;
        tick();
        start_to = 1'b0;
        chk("to_busy", t_busy, 1);
        chk("to_req", t_req, 1);
        repeat (3) tick();
        chk("to_done_early", t_done, 0);
        chk("to_req_hold", t_req, 1);
        tick();
        chk("to_done", t_done, 1);
        chk("to_fault", t_fault, 1);
        chk("to_req_drop", t_req, 0);
        chk("to_exc_addr", t_exc_addr, 32'h500);
        chk("to_rd_valid", t_rd_valid, 0);
        tick();
        chk("to_idle", t_busy, 0);

        // Bus error on response
        issue(T_LOAD, OP_LW, 32'h600, 0, 0);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_err = 1'b1; bus_rdata = 32'h1111_2222;
        tick();
        bus_rvalid = 1'b0; bus_err = 1'b0;
        chk("err_done", done, 1);
        chk("err_fault", fault, 1);
        chk("err_rd_valid", rd_valid, 0);
        chk("err_exc_addr", exc_addr, 32'h600);
        tick();

        // Reset during WAIT, then a late response
        issue(T_STORE, 8'h01, 32'h700, 32'hDEAD_BEEF, 0);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        chk("rstw_busy", busy, 1);
        chk("rstw_wdata", wdata, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        chk("rstw_busy_clr", busy, 0);
        chk("rstw_req", req, 0);
        chk("rstw_exc_addr", exc_addr, 0);
        chk("rstw_addr", addr, 0);
        chk("rstw_wdata_clr", wdata, 0);
        chk("rstw_rd_data", rd_data, 0);
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
        tick();
        bus_rvalid = 1'b0;
        chk("late_busy", busy, 0);
        chk("late_done", done, 0);
        chk("late_rd_valid", rd_valid, 0);

        // Access after reset works
        issue(T_LOAD, OP_LW, 32'h7FC, 0, 4);
        chk("post_addr", addr, 32'h800);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFE_F00D;
        tick();
        bus_rvalid = 1'b0;
        chk("post_done", done, 1);
        chk("post_rd_data", rd_data, 32'hCAFE_F00D);
        tick();
        chk("post_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
